// File: rtl/othello_ui_pkg.sv
// Shared constants for the Othello mouse UI blocks.
//   GRID        board is GRID x GRID cells
//   CELL_IDX_W  width of a row/col index
//   CNT_W       width of the divider quotient counters (must hold GRID)
//   ST_*        click FSM state encodings
package othello_ui_pkg;
  localparam int GRID       = 8;
  localparam int CELL_IDX_W = 3;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] GRID_CNT = CNT_W'(GRID);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DIVIDE   = 2'd1;
  localparam logic [1:0] ST_OFFER    = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;
endpackage

// File: rtl/mouse_cell_picker_if.sv
// Picker <-> game logic bus.
//   move_valid/move_row/move_col  cell request, held until move_ready
//   move_ready                    game logic accepts the request
//   pass_pulse                    one-cycle right-button pass
//   hover_valid/hover_row/col     pointer cell (zero when hover is built out)
// master = picker side, slave = game logic side.
interface mouse_cell_picker_if;
  import othello_ui_pkg::*;

  logic                  move_valid;
  logic [CELL_IDX_W-1:0] move_row;
  logic [CELL_IDX_W-1:0] move_col;
  logic                  move_ready;
  logic                  pass_pulse;
  logic                  hover_valid;
  logic [CELL_IDX_W-1:0] hover_row;
  logic [CELL_IDX_W-1:0] hover_col;

  modport master (
    output move_valid, move_row, move_col, pass_pulse,
           hover_valid, hover_row, hover_col,
    input  move_ready
  );

  modport slave (
    input  move_valid, move_row, move_col, pass_pulse,
           hover_valid, hover_row, hover_col,
    output move_ready
  );
endinterface

// File: rtl/mouse_cell_divider.sv
// Pixel -> board cell by repeated subtraction, one subtraction per axis per cycle.
//   clock, reset  clock, synchronous active-low reset
//   start         load x/y (takes priority over a finishing run)
//   x, y          pixel position
//   x0, y0        board origin
//   cw, ch        cell size (non-zero)
//   done          combinational, high for the one cycle the result is final
//   in_board      with done: position lies on the board
//   row, col      with done & in_board: cell index
module mouse_cell_divider
  import othello_ui_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8:0]            x,
  input  logic [8:0]            y,
  input  logic [8:0]            x0,
  input  logic [8:0]            y0,
  input  logic [8:0]            cw,
  input  logic [8:0]            ch,
  output logic                  done,
  output logic                  in_board,
  output logic [CELL_IDX_W-1:0] row,
  output logic [CELL_IDX_W-1:0] col
);
  logic             busy, outside;
  logic [8:0]       rx, ry;
  logic [CNT_W-1:0] cx, cy;
  logic             ovf, fits;

  // A counter hitting GRID means the pointer is right of / below the board.
  assign ovf      = (cx == GRID_CNT) | (cy == GRID_CNT);
  assign fits     = (rx < cw) & (ry < ch);
  assign done     = busy & (outside | ovf | fits);
  assign in_board = ~outside & ~ovf;
  assign row      = cy[CELL_IDX_W-1:0];
  assign col      = cx[CELL_IDX_W-1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy    <= 1'b0;
      outside <= 1'b0;
      rx      <= '0;
      ry      <= '0;
      cx      <= '0;
      cy      <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      // Left of / above the origin: finish next cycle as off-board.
      outside <= (x < x0) | (y < y0);
      rx      <= x - x0;
      ry      <= y - y0;
      cx      <= '0;
      cy      <= '0;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (rx >= cw) begin
        rx <= rx - cw;
        cx <= cx + 1'b1;
      end
      if (ry >= ch) begin
        ry <= ry - ch;
        cy <= cy + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mouse_cell_picker.sv
// Turns mouse tracker clicks into Othello board cell requests.
//   clock, reset             clock, synchronous active-low reset
//   enable                   accept new clicks (gates IDLE capture only)
//   x_pos, y_pos             mouse position
//   left_click, right_click  button levels
//   game                     mouse_cell_picker_if.master: move request
//                            handshake, pass pulse, hover cell
// Left press on the board -> one move request per physical press.
// Right press in IDLE (no simultaneous left press) -> one-cycle pass_pulse.
// Build option MOUSE_PICK_HOVER_EN: adds a free-running second divider that
// tracks the cell under the pointer; otherwise hover_* are tied low.
module mouse_cell_picker
  import othello_ui_pkg::*;
#(
  parameter logic [8:0] BOARD_X0 = 9'd20,
  parameter logic [8:0] BOARD_Y0 = 9'd0,
  parameter logic [8:0] CELL_W   = 9'd15,
  parameter logic [8:0] CELL_H   = 9'd15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [8:0]          x_pos,
  input  logic [8:0]          y_pos,
  input  logic                left_click,
  input  logic                right_click,
  mouse_cell_picker_if.master game
);
  logic [1:0]            state;
  logic                  prev_left, prev_right;
  logic                  left_press, right_press, outside, click_start;
  logic                  click_done, click_in;
  logic [CELL_IDX_W-1:0] click_row, click_col;
  logic                  move_valid_q, pass_q;
  logic [CELL_IDX_W-1:0] move_row_q, move_col_q;

  assign left_press  = left_click & ~prev_left;
  assign right_press = right_click & ~prev_right;
  assign outside     = (x_pos < BOARD_X0) | (y_pos < BOARD_Y0);
  assign click_start = (state == ST_IDLE) & enable & left_press & ~outside;

  mouse_cell_divider u_click (
    .clock    (clock),
    .reset    (reset),
    .start    (click_start),
    .x        (x_pos),
    .y        (y_pos),
    .x0       (BOARD_X0),
    .y0       (BOARD_Y0),
    .cw       (CELL_W),
    .ch       (CELL_H),
    .done     (click_done),
    .in_board (click_in),
    .row      (click_row),
    .col      (click_col)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      // Reset high so a button held through reset does not look like a press.
      prev_left    <= 1'b1;
      prev_right   <= 1'b1;
      move_valid_q <= 1'b0;
      move_row_q   <= '0;
      move_col_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      prev_left  <= left_click;
      prev_right <= right_click;
      pass_q     <= (state == ST_IDLE) & enable & right_press & ~left_press;
      case (state)
        ST_IDLE:
          if (enable & left_press) state <= outside ? ST_WAIT_REL : ST_DIVIDE;
        ST_DIVIDE:
          if (click_done) begin
            if (click_in) begin
              move_row_q   <= click_row;
              move_col_q   <= click_col;
              move_valid_q <= 1'b1;
              state        <= ST_OFFER;
            end else begin
              state <= ST_WAIT_REL;
            end
          end
        ST_OFFER:
          if (game.move_ready) begin
            move_valid_q <= 1'b0;
            state        <= ST_WAIT_REL;
          end
        ST_WAIT_REL:
          if (!left_click) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game.move_valid = move_valid_q;
  assign game.move_row   = move_row_q;
  assign game.move_col   = move_col_q;
  assign game.pass_pulse = pass_q;

`ifdef MOUSE_PICK_HOVER_EN
  logic                  hov_run, hov_done, hov_in;
  logic [CELL_IDX_W-1:0] hov_row, hov_col;
  logic                  hover_valid_q;
  logic [CELL_IDX_W-1:0] hover_row_q, hover_col_q;

  // Restarts on the cycle it finishes, so it free-runs on the live position.
  mouse_cell_divider u_hover (
    .clock    (clock),
    .reset    (reset),
    .start    (~hov_run | hov_done),
    .x        (x_pos),
    .y        (y_pos),
    .x0       (BOARD_X0),
    .y0       (BOARD_Y0),
    .cw       (CELL_W),
    .ch       (CELL_H),
    .done     (hov_done),
    .in_board (hov_in),
    .row      (hov_row),
    .col      (hov_col)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      hov_run       <= 1'b0;
      hover_valid_q <= 1'b0;
      hover_row_q   <= '0;
      hover_col_q   <= '0;
    end else begin
      hov_run <= 1'b1;
      if (hov_done) begin
        hover_valid_q <= hov_in;
        hover_row_q   <= hov_in ? hov_row : '0;
        hover_col_q   <= hov_in ? hov_col : '0;
      end
    end
  end

  assign game.hover_valid = hover_valid_q;
  assign game.hover_row   = hover_row_q;
  assign game.hover_col   = hover_col_q;
`else
  assign game.hover_valid = 1'b0;
  assign game.hover_row   = '0;
  assign game.hover_col   = '0;
`endif
endmodule

// File: tb/tb_mouse_cell_picker.sv
// Directed bench for mouse_cell_picker: latency, boundaries, handshake hold,
// pass pulse, enable gating and reset in mid-transaction.
module tb_mouse_cell_picker;
  logic       clock = 1'b0;
  logic       reset, enable, left_click, right_click;
  logic [8:0] x_pos, y_pos;
  int         tests = 0, fails = 0;

  always #5 clock = ~clock;

  mouse_cell_picker_if game_if ();

  mouse_cell_picker dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .left_click  (left_click),
    .right_click (right_click),
    .game        (game_if)
  );

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Press left at (x,y); lat = ticks until move_valid, -1 if none within bound.
  task automatic press_wait(input int x, input int y, input int bound, output int lat);
    x_pos = 9'(x);
    y_pos = 9'(y);
    left_click = 1'b1;
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (game_if.move_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_left();
    left_click = 1'b0;
    tick();
    tick();
  endtask

  task automatic accept();
    game_if.move_ready = 1'b1;
    tick();
    chk("accept_valid_drop", int'(game_if.move_valid), 0);
    game_if.move_ready = 1'b0;
  endtask

  initial begin
    int lat, bad;
    reset = 1'b0; enable = 1'b1; left_click = 1'b0; right_click = 1'b0;
    x_pos = '0; y_pos = '0; game_if.move_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", int'(game_if.move_valid), 0);
    chk("rst_row", int'(game_if.move_row), 0);
    chk("rst_col", int'(game_if.move_col), 0);
    chk("rst_pass", int'(game_if.pass_pulse), 0);
    chk("rst_hover", int'(game_if.hover_valid), 0);
    reset = 1'b1;
    tick();

    // 1: top-left cell, minimum latency
    press_wait(20, 0, 15, lat);
    chk("t1_lat", lat, 2);
    chk("t1_row", int'(game_if.move_row), 0);
    chk("t1_col", int'(game_if.move_col), 0);
    accept();
    release_left();

    // 2: bottom-right cell, maximum accepted latency
    press_wait(139, 119, 15, lat);
    chk("t2_lat", lat, 9);
    chk("t2_row", int'(game_if.move_row), 7);
    chk("t2_col", int'(game_if.move_col), 7);
    accept();
    release_left();

    // 3: left of board, then column 8
    press_wait(19, 50, 12, lat);
    chk("t3_left_of_board", lat, -1);
    release_left();
    press_wait(140, 50, 12, lat);
    chk("t3_col8", lat, -1);
    release_left();

    // 4: cell (3,4) held under backpressure, one request per press
    press_wait(85, 50, 15, lat);
    chk("t4_lat", lat, 6);
    chk("t4_row", int'(game_if.move_row), 3);
    chk("t4_col", int'(game_if.move_col), 4);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!game_if.move_valid || game_if.move_row != 3'd3 || game_if.move_col != 3'd4) bad++;
    end
    chk("t4_stable_cycles_bad", bad, 0);
    accept();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (game_if.move_valid) bad++;
    end
    chk("t4_held_no_second", bad, 0);
    release_left();
    press_wait(85, 50, 15, lat);
    chk("t4_repress_lat", lat, 6);
    accept();
    release_left();

    // 5: pass pulse, and right+left together
    right_click = 1'b1;
    tick();
    chk("t5_pass_hi", int'(game_if.pass_pulse), 1);
    tick();
    chk("t5_pass_lo", int'(game_if.pass_pulse), 0);
    right_click = 1'b0;
    tick();
    right_click = 1'b1;
    x_pos = 9'd20; y_pos = 9'd0; left_click = 1'b1;
    tick();
    chk("t5_both_no_pass", int'(game_if.pass_pulse), 0);
    tick();
    chk("t5_both_move", int'(game_if.move_valid), 1);
    chk("t5_both_pass_lo", int'(game_if.pass_pulse), 0);
    accept();
    right_click = 1'b0;
    release_left();

    // enable low: clicks ignored
    enable = 1'b0;
    right_click = 1'b1;
    press_wait(20, 0, 12, lat);
    chk("en_off_no_move", lat, -1);
    chk("en_off_no_pass", int'(game_if.pass_pulse), 0);
    right_click = 1'b0;
    release_left();
    enable = 1'b1;

    // 6: reset during DIVIDE, then during OFFER; button held across release
    x_pos = 9'd139; y_pos = 9'd119; left_click = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("t6_div_rst_valid", int'(game_if.move_valid), 0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (game_if.move_valid) bad++;
    end
    chk("t6_div_held_no_req", bad, 0);
    release_left();
    press_wait(139, 119, 15, lat);
    chk("t6_offer_lat", lat, 9);
    reset = 1'b0;
    tick();
    chk("t6_offer_rst_valid", int'(game_if.move_valid), 0);
    chk("t6_offer_rst_row", int'(game_if.move_row), 0);
    chk("t6_offer_rst_col", int'(game_if.move_col), 0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (game_if.move_valid) bad++;
    end
    chk("t6_offer_held_no_req", bad, 0);
    release_left();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
